ptp_queue_sc: RTL
=================

# ptp_queue_sc

Parametrised single-clock timestamp queue: the next generation of the PTP timestamp FIFO. It buffers DW-bit PTP descriptors (timestamp plus sequence/port fields) between the timestamp capture logic and the descriptor consumer when both run on one clock. Over the fixed 128×16 dual-clock queue it adds:
- parametrised width, depth and almost-full threshold;
- show-ahead output;
- selectable overflow policy (reject new / overwrite oldest);
- synchronous flush;
- saturating drop and underflow counters.

## Interface
- DW, 128, data width in bits
- AW, 4, address width; depth DEPTH = 2^AW
- AFULL, 12, almost_full asserts when usedw >= AFULL (1..DEPTH)
- OVERWRITE, 0, 0 = reject write when full; 1 = discard oldest entry and accept write when full
- clk  input  1  single clock, rising edge
- aclr  input  1  reset, synchronous, active-high
- flush  input  1  synchronous queue clear
- data  input  DW  write data
- wrreq  input  1  write request
- rdreq  input  1  read (pop) request; acknowledges the word shown on q
- q  output  DW  head-of-queue word (show-ahead), registered
- empty  output  1  queue empty
- full  output  1  usedw == DEPTH
- almost_full  output  1  usedw >= AFULL
- usedw  output  AW+1  occupancy, 0..DEPTH
- drop_cnt  output  16  writes lost to overflow, saturating
- underflow_cnt  output  16  rdreq while empty, saturating

## Operation
- Storage: DEPTH×DW memory, write pointer and read pointer of AW bits each, wrapping modulo DEPTH. Occupancy is tracked in the separate usedw register, so full and empty are unambiguous.
- Show-ahead: whenever empty=0, q holds the oldest entry. rdreq pops it.
- Priority per cycle: aclr > flush > normal operation.
- Normal operation, with eff_rd = rdreq & !empty:
  - Not full: write accepted.
  - Full with eff_rd: write accepted, usedw unchanged.
  - Full without eff_rd, OVERWRITE=0: write discarded, drop_cnt += 1.
  - Full without eff_rd, OVERWRITE=1: oldest entry discarded, read pointer advances, data written, usedw stays DEPTH, drop_cnt += 1. q shows the new oldest entry the next cycle.
  - Empty with rdreq and wrreq in the same cycle: read ignored, underflow_cnt += 1, write accepted.
  - rdreq while empty: no pointer change, underflow_cnt += 1.
- usedw update: +1 on an accepted write without eff_rd; −1 on eff_rd without a write; otherwise unchanged. In overwrite mode a full write leaves usedw unchanged.
- Counters saturate at 0xFFFF. They are cleared only by aclr, never by flush.
- Flush: pointers and usedw go to 0, empty=1, q=0 next cycle. wrreq and rdreq in the flush cycle are ignored and do not touch the counters.
- No state machine beyond the pointer/occupancy datapath. Flag outputs are registered and derived from the next usedw value.

## Timing
- Reset values (cycle after aclr is sampled high): q=0, empty=1, full=0, almost_full=0, usedw=0, drop_cnt=0, underflow_cnt=0. Memory contents are undefined and never observable.
- Write-to-output latency: a write into an empty queue at edge N gives empty=0 and q=data after edge N, so the word is visible in cycle N+1.
- Pop: rdreq sampled at edge N. The next entry appears on q after edge N. If the queue becomes empty, empty=1 after edge N and q holds its last value.
- usedw, full and almost_full all update on the same edge as the accepting write or read. No flag lags occupancy.
- Back-to-back writes and reads at one per cycle are sustained with no bubbles, including across pointer wrap-around.
- aclr or flush asserted mid-burst takes effect at that edge. Traffic resumes on the following cycle.

## Test plan
- Reset then fill (DW=128, AW=4, AFULL=12): 16 writes of 0..15. Required: almost_full=1 after the 12th write; full=1 and usedw=16 after the 16th; q=0 from the cycle after the first write.
- Overflow, OVERWRITE=0: full queue holding 0..15, write 0xAA. Required: drop_cnt=1; 16 pops return 0..15 in order; then empty=1.
- Overflow, OVERWRITE=1: full queue holding 0..15, write 0xAA then 0xBB. Required: drop_cnt=2, usedw=16; pops return 2..15, 0xAA, 0xBB.
- Simultaneous: full queue with rdreq+wrreq gives usedw=16 and drop_cnt=0. Empty queue with rdreq+wrreq(0x55) gives underflow_cnt=1, usedw=1, q=0x55 next cycle.
- Wrap-around streaming: 100 cycles of simultaneous write/read at steady usedw=3. Required: output sequence equals input sequence delayed by three entries, with no gaps.
- Flush and aclr: flush with usedw=7 while wrreq=1. Required: usedw=0, empty=1 next cycle, and drop_cnt and underflow_cnt retained. A subsequent aclr clears both counters to 0.

Source files
------------

// File: rtl/ptp_queue_sc.sv
// Single-clock PTP descriptor queue with show-ahead output, selectable overflow
// policy, synchronous flush and saturating drop/underflow counters.
module ptp_queue_sc #(
  parameter int DW        = 128,
  parameter int AW        = 4,
  parameter int AFULL     = 12,
  parameter int OVERWRITE = 0
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          flush,
  input  logic [DW-1:0] data,
  input  logic          wrreq,
  input  logic          rdreq,
  output logic [DW-1:0] q,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   usedw,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   underflow_cnt
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_W = (AW+1)'(AFULL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   usedw_nxt;
  logic          eff_rd;
  logic          ovw;
  logic          drop;
  logic          wr_ok;
  logic          under;
  logic          head_is_new;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    eff_rd     = rdreq & ~empty;
    drop       = wrreq & full & ~eff_rd;
    ovw        = drop & (OVERWRITE != 0);
    wr_ok      = wrreq & (~full | eff_rd | ovw);
    under      = rdreq & empty;
    rd_ptr_nxt = rd_ptr + AW'(eff_rd | ovw);
    usedw_nxt  = usedw;
    if (wr_ok & ~eff_rd & ~full)
      usedw_nxt = usedw + (AW+1)'(1);
    else if (eff_rd & ~wr_ok)
      usedw_nxt = usedw - (AW+1)'(1);
    // The incoming word becomes the head only when nothing older survives this edge.
    head_is_new = wr_ok & (usedw == (AW+1)'(eff_rd));
  end

  always_ff @(posedge clk) begin
    if (wr_ok & ~flush & ~aclr)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      usedw         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      almost_full   <= 1'b0;
      drop_cnt      <= '0;
      underflow_cnt <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr      <= rd_ptr_nxt;
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == DEPTH_W);
      almost_full <= (usedw_nxt >= AFULL_W);
      if (drop)
        drop_cnt <= sat_inc(drop_cnt);
      if (under)
        underflow_cnt <= sat_inc(underflow_cnt);
    end
  end

  // Show-ahead head register: holds its last value once the queue drains.
  always_ff @(posedge clk) begin
    if (aclr || flush)
      q <= '0;
    else if (head_is_new)
      q <= data;
    else if (usedw_nxt != '0)
      q <= mem[rd_ptr_nxt];
  end

endmodule
